dds_prng: RTL and testbench

Free-running pseudorandom byte source for the DDS output mux (mode `11`, noise output). It holds a 32-bit maximal-length Galois LFSR and advances it several bits every clock. Each clock it presents a fresh 8-bit value. It has no control inputs; it runs continuously out of reset.

---
 rtl/dds_prng_pkg.sv | 16 +
 rtl/dds_prng_step.sv | 11 +
 rtl/dds_prng.sv | 50 +++++
 tb/tb_dds_prng.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dds_prng_pkg.sv
// Shared types, constants and the single-bit Galois step for the DDS noise source.
package dds_prng_pkg;

  localparam int LFSR_W = 32;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t TAP_MASK     = 32'h8020_0003;
  localparam lfsr_t DEFAULT_SEED = 32'h0000_0001;

  // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
  function automatic lfsr_t galois_step(lfsr_t s);
    return (s >> 1) ^ (s[0] ? TAP_MASK : '0);
  endfunction

endpackage

// File: rtl/dds_prng_step.sv
// Purely combinational single-bit LFSR advance; chained STEPS times by dds_prng.
module dds_prng_step
  import dds_prng_pkg::*;
(
  input  lfsr_t state_in,
  output lfsr_t state_out
);

  assign state_out = galois_step(state_in);

endmodule

// File: rtl/dds_prng.sv
// Free-running 32-bit Galois LFSR byte source advancing STEPS bits per clock.
// Optional DDS_PRNG_WHITEN_EN folds all four state bytes into the output.
module dds_prng
  import dds_prng_pkg::*;
#(
  parameter lfsr_t SEED  = DEFAULT_SEED,
  parameter int    STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] prng_data
);

  // An all-zero seed would lock the LFSR, so it is replaced by the default
  localparam lfsr_t EFF_SEED = (SEED == '0) ? DEFAULT_SEED : SEED;

  if (STEPS < 1 || STEPS > 32) begin : g_bad_steps
    $error("dds_prng: STEPS must be in 1..32");
  end

  lfsr_t lfsr;
  lfsr_t lfsr_next;
  lfsr_t chain [0:STEPS];

  assign chain[0] = lfsr;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    dds_prng_step u_step (
      .state_in  (chain[i]),
      .state_out (chain[i+1])
    );
  end

  assign lfsr_next = (lfsr == '0) ? EFF_SEED : chain[STEPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= EFF_SEED;
    end else begin
      lfsr <= lfsr_next;
    end
  end

`ifdef DDS_PRNG_WHITEN_EN
  assign prng_data = lfsr[31:24] ^ lfsr[23:16] ^ lfsr[15:8] ^ lfsr[7:0];
`else
  assign prng_data = lfsr[7:0];
`endif

endmodule

// File: tb/tb_dds_prng.sv
// Self-checking bench for dds_prng: four instances checked every cycle against a
// bit-serial reference model, plus literal pins, reset restarts and statistics.
module tb_dds_prng;

  localparam logic [31:0] TAP    = 32'h8020_0003;
  localparam logic [31:0] SEED32 = 32'hACE1_2345;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] d8, d1, d0, d32;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m8, m1, m0, m32;
  logic [7:0]  rec [0:99];
  int          ones [0:7];
  bit          seen [0:255];

  always #5 clk = ~clk;

  dds_prng dut8 (.clk(clk), .rst_n(rst_n), .prng_data(d8));
  dds_prng #(.SEED(32'h0000_0001), .STEPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .prng_data(d1));
  dds_prng #(.SEED(32'h0000_0000), .STEPS(8)) dut0 (.clk(clk), .rst_n(rst_n), .prng_data(d0));
  dds_prng #(.SEED(SEED32), .STEPS(32)) dut32 (.clk(clk), .rst_n(rst_n), .prng_data(d32));

  // Reference: shift the register right n times, XORing in the taps whenever a 1 falls out
  function automatic logic [31:0] advance(logic [31:0] s, int n);
    logic [31:0] r = s;
    for (int i = 0; i < n; i++) begin
      r = (r >> 1) ^ (((r & 32'd1) != 0) ? TAP : 32'd0);
    end
    return r;
  endfunction

  function automatic logic [7:0] fold(logic [31:0] s);
`ifdef DDS_PRNG_WHITEN_EN
    return s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Async reset pulse placed strictly between clock edges
  task automatic applyStimulus(input int lead, input int hold_cycles, input int tail);
    @(posedge clk);
    #(lead);
    rst_n = 1'b0;
    repeat (hold_cycles) @(posedge clk);
    #(tail);
    rst_n = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8  <= 32'h0000_0001;
      m1  <= 32'h0000_0001;
      m0  <= 32'h0000_0001;
      m32 <= SEED32;
    end else begin
      m8  <= advance(m8, 8);
      m1  <= advance(m1, 1);
      m0  <= advance(m0, 8);
      m32 <= advance(m32, 32);
    end
  end

  always @(negedge clk) begin
    checkOutput("dut8_data",  {24'd0, d8},  {24'd0, fold(m8)});
    checkOutput("dut1_data",  {24'd0, d1},  {24'd0, fold(m1)});
    checkOutput("dut0_data",  {24'd0, d0},  {24'd0, fold(m0)});
    checkOutput("dut32_data", {24'd0, d32}, {24'd0, fold(m32)});
    checkOutput("dut0_state", dut0.lfsr, m0);
    checkOutput("dut0_nonzero", {31'd0, (dut0.lfsr != 32'd0)}, 32'd1);
  end

  initial begin
    logic [31:0] exp1 [0:3];
    int          missing;
    exp1[0] = 32'h8020_0003;
    exp1[1] = 32'hC030_0002;
    exp1[2] = 32'h6018_0001;
    exp1[3] = 32'hB02C_0003;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_data",  {24'd0, d8}, 32'h0000_0001);
    checkOutput("reset_state", dut8.lfsr, 32'h0000_0001);
    checkOutput("seed0_state", dut0.lfsr, 32'h0000_0001);
    checkOutput("seed0_data",  {24'd0, d0}, 32'h0000_0001);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      rec[i] = d8;
      if (i == 0) begin
        checkOutput("first_step_state", dut8.lfsr, 32'hDB36_C002);
`ifdef DDS_PRNG_WHITEN_EN
        checkOutput("first_step_data", {24'd0, d8}, 32'h0000_002F);
`else
        checkOutput("first_step_data", {24'd0, d8}, 32'h0000_0002);
`endif
      end
      if (i < 4) begin
        checkOutput($sformatf("steps1_state%0d", i), dut1.lfsr, exp1[i]);
      end
    end

    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_state", dut8.lfsr, 32'h0000_0001);
    checkOutput("midrun_reset_data",  {24'd0, d8}, {24'd0, fold(32'h0000_0001)});
    checkOutput("midrun_reset_s32",   dut32.lfsr, SEED32);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      checkOutput($sformatf("replay%0d", i), {24'd0, d8}, {24'd0, rec[i]});
    end

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(1, 300)) @(posedge clk);
      applyStimulus($urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 4));
    end

    for (int b = 0; b < 8; b++) ones[b] = 0;
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    repeat (65536) begin
      @(negedge clk);
      #1;
      for (int b = 0; b < 8; b++) ones[b] += int'(d8[b]);
      seen[d8] = 1'b1;
    end
`ifndef DDS_PRNG_WHITEN_EN
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("bit%0d_ones", b),
                  {31'd0, (ones[b] * 100 >= 49 * 65536) && (ones[b] * 100 <= 51 * 65536)}, 32'd1);
    end
    missing = 0;
    for (int v = 0; v < 256; v++) if (!seen[v]) missing++;
    checkOutput("bytes_missing", missing, 32'd0);
`endif

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
